// File: rtl/fosfor_present_ctrl_pkg.sv
// fosfor_present_ctrl shared definitions
// bus phases, command codes, status layout, FSM states
package fosfor_present_ctrl_pkg;

  localparam logic [1:0] ADDR_IDLE = 2'd0;
  localparam logic [1:0] ADDR_LOW  = 2'd1;
  localparam logic [1:0] ADDR_HIGH = 2'd2;
  localparam logic [1:0] ADDR_CMD  = 2'd3;

  localparam logic [3:0] CMD_LATCH_ADDRESS = 4'd1;
  localparam logic [3:0] CMD_WRITE         = 4'd2;
  localparam logic [3:0] CMD_START         = 4'd3;

  localparam int unsigned ROUNDS_DEF     = 31;
  localparam int unsigned KEY_OFFSET_DEF = 8;
  localparam int unsigned KEY_BYTES      = 10;

  localparam int unsigned STAT_READY   = 0;
  localparam int unsigned STAT_RND_LSB = 1;
  localparam int unsigned STAT_ERR     = 6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ROUND,
    ST_FINAL
  } state_e;

  function automatic logic [7:0] status_byte(
    input logic       err,
    input logic [4:0] rnd,
    input logic       rdy
  );
    logic [7:0] s;
    s = 8'h00;
    s[STAT_ERR] = err;
    s[STAT_RND_LSB +: 5] = rnd;
    s[STAT_READY] = rdy;
    return s;
  endfunction

endpackage

// File: rtl/fosfor_present_ctrl_if.sv
// fosfor_present_ctrl host nibble bus
// master drives phase/nibble, slave returns the read byte
interface fosfor_present_ctrl_if;
  logic [1:0] Address_b;
  logic [3:0] DataIn_b;
  logic [7:0] DataOut_b;

  modport master (
    output Address_b,
    output DataIn_b,
    input  DataOut_b
  );

  modport slave (
    input  Address_b,
    input  DataIn_b,
    output DataOut_b
  );
endinterface

// File: rtl/fosfor_nibble_bus.sv
// fosfor_nibble_bus: nibble assembly, address latch,
// command decode with one-cycle write/start pulses
module fosfor_nibble_bus
  import fosfor_present_ctrl_pkg::*;
(
  input  logic       Clk_k,
  input  logic       Reset_r,
  input  logic [1:0] Address_i,
  input  logic [3:0] DataIn_i,
  output logic [7:0] WData_o,
  output logic [7:0] Addr_o,
  output logic       CmdWrite_o,
  output logic       CmdStart_o
);

  logic [7:0] wdata_q, wdata_d;
  logic [7:0] addr_q, addr_d;
  logic       is_cmd;
  logic       cmd_latch;

  assign is_cmd     = (Address_i == ADDR_CMD);
  assign cmd_latch  = is_cmd && (DataIn_i == CMD_LATCH_ADDRESS);
  assign CmdWrite_o = is_cmd && (DataIn_i == CMD_WRITE);
  assign CmdStart_o = is_cmd && (DataIn_i == CMD_START);

  always_comb begin
    wdata_d = wdata_q;
    addr_d  = addr_q;
    unique case (1'b1)
      (Address_i == ADDR_LOW):  wdata_d[3:0] = DataIn_i;
      (Address_i == ADDR_HIGH): wdata_d[7:4] = DataIn_i;
      cmd_latch:                addr_d       = wdata_q;
      default: ;
    endcase
  end

  always_ff @(posedge Clk_k or negedge Reset_r) begin
    if (!Reset_r) begin
      wdata_q <= 8'h00;
      addr_q  <= 8'h00;
    end else begin
      wdata_q <= wdata_d;
      addr_q  <= addr_d;
    end
  end

  assign WData_o = wdata_q;
  assign Addr_o  = addr_q;

endmodule

// File: rtl/fosfor_present_ctrl.sv
// fosfor_present_ctrl: PRESENT-80 host control,
// register-file strobes and encryption sequencer
module fosfor_present_ctrl
  import fosfor_present_ctrl_pkg::*;
#(
  parameter int unsigned ROUNDS     = ROUNDS_DEF,
  parameter int unsigned KEY_OFFSET = KEY_OFFSET_DEF
) (
  input  logic                 Clk_k,
  input  logic                 Reset_r,
  fosfor_present_ctrl_if.slave Bus,
  output logic [7:0]           RegAddr_b,
  output logic [7:0]           RegWData_b,
  output logic                 RegWrite_o,
  input  logic [7:0]           RegRData_b,
  output logic                 CoreLoad_o,
  output logic                 CoreRound_o,
  output logic [4:0]           RoundCnt_b,
  output logic                 CoreFinal_o,
  output logic                 Ready_o
);

  localparam logic [4:0] LAST_RND = 5'(ROUNDS);
  localparam logic [8:0] ADDR_END = 9'(KEY_OFFSET + KEY_BYTES);

  state_e     state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic       we_q, we_d;
  logic       err_q, err_d;
  logic [7:0] dout_q, dout_d;
  logic       cmd_write;
  logic       cmd_start;
  logic       in_range;

  fosfor_nibble_bus u_bus (
    .Clk_k      (Clk_k),
    .Reset_r    (Reset_r),
    .Address_i  (Bus.Address_b),
    .DataIn_i   (Bus.DataIn_b),
    .WData_o    (RegWData_b),
    .Addr_o     (RegAddr_b),
    .CmdWrite_o (cmd_write),
    .CmdStart_o (cmd_start)
  );

  assign in_range = ({1'b0, RegAddr_b} < ADDR_END);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    CoreLoad_o  = 1'b0;
    CoreRound_o = 1'b0;
    CoreFinal_o = 1'b0;
    Ready_o     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        Ready_o = 1'b1;
        if (cmd_start) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        CoreLoad_o = 1'b1;
        state_d    = ST_ROUND;
        cnt_d      = 5'd1;
      end
      ST_ROUND: begin
        CoreRound_o = 1'b1;
        if (cnt_q == LAST_RND) begin
          state_d = ST_FINAL;
          cnt_d   = 5'd0;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      ST_FINAL: begin
        CoreFinal_o = 1'b1;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // busy writes are dropped and flagged; START in IDLE clears the flag
  always_comb begin
    we_d  = cmd_write && Ready_o && in_range;
    err_d = err_q;
    unique case (1'b1)
      (cmd_start && Ready_o):  err_d = 1'b0;
      (cmd_write && !Ready_o): err_d = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    dout_d = dout_q;
    unique case (1'b1)
      (Bus.Address_b == ADDR_LOW):
        dout_d = RegRData_b;
      (Bus.Address_b == ADDR_IDLE):
        dout_d = status_byte(err_q, cnt_q, Ready_o);
      default: ;
    endcase
  end

  always_ff @(posedge Clk_k or negedge Reset_r) begin
    if (!Reset_r) begin
      state_q <= ST_IDLE;
      cnt_q   <= 5'd0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      dout_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      err_q   <= err_d;
      dout_q  <= dout_d;
    end
  end

  assign RoundCnt_b    = cnt_q;
  assign RegWrite_o    = we_q;
  assign Bus.DataOut_b = dout_q;

endmodule

// File: tb/tb_fosfor_present_ctrl.sv
// tb_fosfor_present_ctrl: table vectors, sequences
// and random traffic against a cycle-count model
module tb_fosfor_present_ctrl;
  import fosfor_present_ctrl_pkg::*;

  logic       Clk_k;
  logic       Reset_r;
  logic [7:0] RegAddr_b, RegWData_b, RegRData_b;
  logic       RegWrite_o, CoreLoad_o, CoreRound_o;
  logic       CoreFinal_o, Ready_o;
  logic [4:0] RoundCnt_b;

  fosfor_present_ctrl_if bus ();

  fosfor_present_ctrl dut (
    .Clk_k       (Clk_k),
    .Reset_r     (Reset_r),
    .Bus         (bus),
    .RegAddr_b   (RegAddr_b),
    .RegWData_b  (RegWData_b),
    .RegWrite_o  (RegWrite_o),
    .RegRData_b  (RegRData_b),
    .CoreLoad_o  (CoreLoad_o),
    .CoreRound_o (CoreRound_o),
    .RoundCnt_b  (RoundCnt_b),
    .CoreFinal_o (CoreFinal_o),
    .Ready_o     (Ready_o)
  );

  function automatic logic [7:0] rf(input logic [7:0] a);
    return a ^ 8'hC3;
  endfunction

  assign RegRData_b = rf(RegAddr_b);

  initial Clk_k = 1'b0;
  always #5 Clk_k = ~Clk_k;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // model: m_t = cycles since START edge (0 idle, 1 load,
  // 2..ROUNDS+1 rounds, ROUNDS+2 final)
  localparam int LAST_T = ROUNDS_DEF + 2;
  int         m_t;
  logic [7:0] m_addr, m_wdata, m_dout;
  logic       m_we, m_err;

  function automatic logic [4:0] m_cnt(input int t);
    return (t >= 2 && t <= LAST_T - 1) ? 5'(t - 1) : 5'd0;
  endfunction

  task automatic mdl_reset();
    m_t = 0; m_addr = 0; m_wdata = 0; m_dout = 0;
    m_we = 0; m_err = 0;
  endtask

  task automatic mdl_step(input logic [1:0] a, input logic [3:0] d);
    bit st, wr, la;
    logic [7:0] stat, nd;
    st = (a == 2'd3) && (d == 4'd3);
    wr = (a == 2'd3) && (d == 4'd2);
    la = (a == 2'd3) && (d == 4'd1);
    stat = {1'b0, m_err, m_cnt(m_t), m_t == 0};
    nd = (a == 2'd1) ? rf(m_addr) : (a == 2'd0) ? stat : m_dout;
    m_we = wr && m_t == 0 && m_addr < 8'(KEY_OFFSET_DEF + KEY_BYTES);
    if (st && m_t == 0) m_err = 0;
    else if (wr && m_t != 0) m_err = 1;
    if (la) m_addr = m_wdata;
    if (a == 2'd1) m_wdata[3:0] = d;
    if (a == 2'd2) m_wdata[7:4] = d;
    if (m_t == 0) m_t = st ? 1 : 0;
    else m_t = (m_t == LAST_T) ? 0 : m_t + 1;
    m_dout = nd;
  endtask

  task automatic check_all();
    chk("dout", bus.DataOut_b, m_dout);
    chk("addr", RegAddr_b, m_addr);
    chk("wdata", RegWData_b, m_wdata);
    chk("we", RegWrite_o, m_we);
    chk("ready", Ready_o, m_t == 0);
    chk("load", CoreLoad_o, m_t == 1);
    chk("round", CoreRound_o, m_cnt(m_t) != 0);
    chk("cnt", RoundCnt_b, m_cnt(m_t));
    chk("final", CoreFinal_o, m_t == LAST_T);
  endtask

  task automatic cyc(input logic [1:0] a, input logic [3:0] d);
    @(negedge Clk_k);
    bus.Address_b = a;
    bus.DataIn_b  = d;
    @(posedge Clk_k);
    mdl_step(a, d);
    #1;
    check_all();
  endtask

  task automatic run_seq(input bit inject, output int k);
    cyc(ADDR_CMD, CMD_START);
    chk("t0_ready", Ready_o, 0);
    chk("t0_load", CoreLoad_o, 1);
    k = 0;
    while (!Ready_o && k < 60) begin
      if (inject && k == 3) begin
        cyc(ADDR_CMD, CMD_WRITE);
        chk("busy_we", RegWrite_o, 0);
      end else if (inject && k == 4) begin
        cyc(ADDR_CMD, CMD_START);
      end else begin
        cyc(ADDR_IDLE, 4'h0);
      end
      k++;
      if (k == 6)
        chk("stat_r5", bus.DataOut_b, inject ? 8'h4A : 8'h0A);
    end
    chk("seq_len", k, 33);
  endtask

  typedef struct {
    logic [1:0] a;
    logic [3:0] d;
    logic [7:0] dout;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       we;
  } vec_t;

  vec_t tbl[18];

  initial begin
    int k;
    tbl[0]  = '{2'd0, 4'h0, 8'h01, 8'h00, 8'h00, 1'b0};
    tbl[1]  = '{2'd0, 4'h0, 8'h01, 8'h00, 8'h00, 1'b0};
    tbl[2]  = '{2'd1, 4'hA, 8'hC3, 8'h00, 8'h0A, 1'b0};
    tbl[3]  = '{2'd2, 4'h0, 8'hC3, 8'h00, 8'h0A, 1'b0};
    tbl[4]  = '{2'd3, 4'h1, 8'hC3, 8'h0A, 8'h0A, 1'b0};
    tbl[5]  = '{2'd1, 4'hC, 8'hC9, 8'h0A, 8'h0C, 1'b0};
    tbl[6]  = '{2'd2, 4'h5, 8'hC9, 8'h0A, 8'h5C, 1'b0};
    tbl[7]  = '{2'd3, 4'h2, 8'hC9, 8'h0A, 8'h5C, 1'b1};
    tbl[8]  = '{2'd0, 4'h0, 8'h01, 8'h0A, 8'h5C, 1'b0};
    tbl[9]  = '{2'd1, 4'h2, 8'hC9, 8'h0A, 8'h52, 1'b0};
    tbl[10] = '{2'd2, 4'h1, 8'hC9, 8'h0A, 8'h12, 1'b0};
    tbl[11] = '{2'd3, 4'h1, 8'hC9, 8'h12, 8'h12, 1'b0};
    tbl[12] = '{2'd3, 4'h2, 8'hC9, 8'h12, 8'h12, 1'b0};
    tbl[13] = '{2'd3, 4'hF, 8'hC9, 8'h12, 8'h12, 1'b0};
    tbl[14] = '{2'd1, 4'h1, 8'hD1, 8'h12, 8'h11, 1'b0};
    tbl[15] = '{2'd3, 4'h1, 8'hD1, 8'h11, 8'h11, 1'b0};
    tbl[16] = '{2'd3, 4'h2, 8'hD1, 8'h11, 8'h11, 1'b1};
    tbl[17] = '{2'd0, 4'h0, 8'h01, 8'h11, 8'h11, 1'b0};

    Reset_r = 1'b0;
    bus.Address_b = ADDR_IDLE;
    bus.DataIn_b  = 4'h0;
    mdl_reset();
    repeat (2) @(posedge Clk_k);
    #1;
    chk("rst_dout", bus.DataOut_b, 8'h00);
    chk("rst_ready", Ready_o, 1);
    chk("rst_cnt", RoundCnt_b, 0);
    chk("rst_strobes", {RegWrite_o, CoreLoad_o, CoreRound_o, CoreFinal_o}, 0);
    #1 Reset_r = 1'b1;

    foreach (tbl[i]) begin
      cyc(tbl[i].a, tbl[i].d);
      chk($sformatf("tbl%0d_dout", i), bus.DataOut_b, tbl[i].dout);
      chk($sformatf("tbl%0d_addr", i), RegAddr_b, tbl[i].addr);
      chk($sformatf("tbl%0d_wdata", i), RegWData_b, tbl[i].wdata);
      chk($sformatf("tbl%0d_we", i), RegWrite_o, tbl[i].we);
    end

    run_seq(1'b0, k);
    run_seq(1'b1, k);
    cyc(ADDR_IDLE, 4'h0);
    chk("err_set", bus.DataOut_b, 8'h41);
    run_seq(1'b0, k);
    cyc(ADDR_IDLE, 4'h0);
    chk("err_clr", bus.DataOut_b, 8'h01);

    cyc(ADDR_CMD, CMD_START);
    k = 0;
    while (RoundCnt_b != 5'd12 && k < 60) begin
      cyc(ADDR_IDLE, 4'h0);
      k++;
    end
    chk("reach_r12", RoundCnt_b, 12);
    @(negedge Clk_k);
    Reset_r = 1'b0;
    #1;
    mdl_reset();
    chk("mid_rst_ready", Ready_o, 1);
    chk("mid_rst_cnt", RoundCnt_b, 0);
    chk("mid_rst_round", CoreRound_o, 0);
    chk("mid_rst_dout", bus.DataOut_b, 8'h00);
    @(posedge Clk_k);
    #2 Reset_r = 1'b1;
    run_seq(1'b0, k);

    for (int i = 0; i < 600; i++) begin
      logic [1:0] a;
      logic [3:0] d;
      a = 2'($urandom_range(0, 3));
      d = 4'($urandom_range(0, 15));
      if (a == 2'd3 && $urandom_range(0, 3) != 0)
        d = 4'($urandom_range(0, 3));
      if (a == 2'd2 && $urandom_range(0, 1) == 1)
        d = 4'($urandom_range(0, 1));
      cyc(a, d);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
